sha256_padder: RTL and testbench

Upstream stage of the SHA-256 datapath. Accepts a message as a stream of 32-bit big-endian words with a valid/ready handshake. Applies FIPS 180-4 padding: a 0x80 byte, zero fill, and the 64-bit bit-length. Hands the resulting 512-bit blocks to the hash controller/message-schedule pair, with first_block/last_block qualifiers, gated by the controller's busy output.

---
 rtl/sha256_pkg.sv | 18 +
 rtl/sha256_byte_mask.sv | 26 ++
 rtl/sha256_padder.sv | 201 ++++++++++++++++++++
 tb/tb_sha256_padder.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 padding stage.
package sha256_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StPad,
    StLen,
    StIssue,
    StWait
  } state_e;

  localparam logic [7:0]  PAD_BYTE    = 8'h80;
  localparam int unsigned LEN_WORD_HI = 14;
  localparam int unsigned LEN_WORD_LO = 15;
  localparam int unsigned BLOCK_WORDS = 16;

endpackage

// File: rtl/sha256_byte_mask.sv
// Zeroes the unused bytes of an incoming word and, on the final word, inserts the 0x80 marker.
module sha256_byte_mask
  import sha256_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  bytes_i,
  input  logic        last_i,
  output logic [31:0] word_o,
  output logic        ovf_o
);

  always_comb begin
    word_o = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i < 32'(bytes_i)) begin
        word_o[31-8*i -: 8] = data_i[31-8*i -: 8];
      end else if (last_i && (i == 32'(bytes_i))) begin
        word_o[31-8*i -: 8] = PAD_BYTE;
      end
    end
  end

  // A full final word leaves no room for the marker; it spills into the next word.
  assign ovf_o = last_i && (bytes_i >= 3'd4);

endmodule

// File: rtl/sha256_padder.sv
// Collects message words into 512-bit blocks, appends FIPS 180-4 padding and the bit length,
// and hands each block to the hash controller when it is not busy.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  input  logic         core_busy,
  output logic [511:0] blk_data,
  output logic         blk_start,
  output logic         first_block,
  output logic         last_block
);

  typedef logic [0:BLOCK_WORDS-1][31:0] block_t;

  state_e           state_q, state_d;
  block_t           buf_q, buf_d;
  logic [3:0]       widx_q, widx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             pend_q, pend_d;
  logic             pend80_q, pend80_d;
  logic             seen_q, seen_d;
  logic [511:0]     blk_data_q, blk_data_d;
  logic             blk_start_q, blk_start_d;
  logic             first_block_q, first_block_d;
  logic             last_block_q, last_block_d;

  logic [31:0] mask_word;
  logic        mask_ovf;
  logic [3:0]  pad_pos;
  logic [63:0] len64;

  sha256_byte_mask u_mask (
    .data_i  (in_data),
    .bytes_i (in_bytes),
    .last_i  (in_last),
    .word_o  (mask_word),
    .ovf_o   (mask_ovf)
  );

  assign pad_pos  = mask_ovf ? widx_q + 4'd1 : widx_q;
  assign len64    = 64'(len_q);
  assign in_ready = (state_q == StFill);

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    widx_d        = widx_q;
    len_d         = len_q;
    first_d       = first_q;
    last_d        = last_q;
    pend_d        = pend_q;
    pend80_d      = pend80_q;
    seen_d        = seen_q;
    blk_data_d    = blk_data_q;
    blk_start_d   = 1'b0;
    first_block_d = 1'b0;
    last_block_d  = 1'b0;

    unique case (state_q)
      StIdle: state_d = StFill;
      StFill: begin
        if (in_valid) begin
          buf_d[widx_q] = mask_word;
          len_d         = len_q + LEN_W'({in_bytes, 3'b000});
          if (!in_last) begin
            widx_d = widx_q + 4'd1;
            if (widx_q == 4'(LEN_WORD_LO)) begin
              state_d = StIssue;
              last_d  = 1'b0;
            end
          end else if (mask_ovf && (widx_q == 4'(LEN_WORD_LO))) begin
            // Marker lands in word 0 of the following block.
            state_d  = StIssue;
            last_d   = 1'b0;
            pend_d   = 1'b1;
            pend80_d = 1'b1;
          end else begin
            if (mask_ovf) buf_d[pad_pos] = {PAD_BYTE, 24'h0};
            if (pad_pos == 4'(LEN_WORD_LO)) begin
              state_d  = StIssue;
              last_d   = 1'b0;
              pend_d   = 1'b1;
              pend80_d = 1'b0;
            end else if (pad_pos == 4'(LEN_WORD_HI - 1)) begin
              state_d = StLen;
            end else begin
              widx_d  = pad_pos + 4'd1;
              state_d = StPad;
            end
          end
        end
      end
      StPad: begin
        buf_d[widx_q] = '0;
        if (widx_q == 4'(LEN_WORD_LO)) begin
          state_d  = StIssue;
          last_d   = 1'b0;
          pend_d   = 1'b1;
          pend80_d = 1'b0;
        end else if (widx_q == 4'(LEN_WORD_HI - 1)) begin
          state_d = StLen;
        end else begin
          widx_d = widx_q + 4'd1;
        end
      end
      StLen: begin
        buf_d[LEN_WORD_HI] = len64[63:32];
        buf_d[LEN_WORD_LO] = len64[31:0];
        state_d            = StIssue;
        last_d             = 1'b1;
        pend_d             = 1'b0;
      end
      StIssue: begin
        if (!core_busy) begin
          blk_start_d   = 1'b1;
          blk_data_d    = buf_q;
          first_block_d = first_q;
          last_block_d  = last_q;
          first_d       = 1'b0;
          seen_d        = 1'b0;
          state_d       = StWait;
        end
      end
      StWait: begin
        // Block is consumed once the controller has gone busy and then idle again.
        if (core_busy) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          seen_d = 1'b0;
          if (last_q) begin
            len_d   = '0;
            widx_d  = '0;
            first_d = 1'b1;
            state_d = StFill;
          end else if (pend_q) begin
            pend_d  = 1'b0;
            state_d = StPad;
            if (pend80_q) begin
              buf_d[0] = {PAD_BYTE, 24'h0};
              widx_d   = 4'd1;
            end else begin
              widx_d = 4'd0;
            end
          end else begin
            state_d = StFill;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      buf_q         <= '0;
      widx_q        <= '0;
      len_q         <= '0;
      first_q       <= 1'b1;
      last_q        <= 1'b0;
      pend_q        <= 1'b0;
      pend80_q      <= 1'b0;
      seen_q        <= 1'b0;
      blk_data_q    <= '0;
      blk_start_q   <= 1'b0;
      first_block_q <= 1'b0;
      last_block_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      widx_q        <= widx_d;
      len_q         <= len_d;
      first_q       <= first_d;
      last_q        <= last_d;
      pend_q        <= pend_d;
      pend80_q      <= pend80_d;
      seen_q        <= seen_d;
      blk_data_q    <= blk_data_d;
      blk_start_q   <= blk_start_d;
      first_block_q <= first_block_d;
      last_block_q  <= last_block_d;
    end
  end

  assign blk_data    = blk_data_q;
  assign blk_start   = blk_start_q;
  assign first_block = first_block_q;
  assign last_block  = last_block_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: directed padding cases, busy back-pressure, reset, and random messages
// checked against a byte-level FIPS 180-4 padding model.
module tb_sha256_padder;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_last = 1'b0;
  logic [2:0]   in_bytes = '0;
  logic         core_busy = 1'b0;
  logic [511:0] blk_data;
  logic         blk_start;
  logic         first_block;
  logic         last_block;

  int n_checks = 0;
  int n_fail   = 0;

  bit auto_busy = 1'b1;
  int busy_cnt  = 0;

  logic [511:0] got_data[$];
  logic         got_first[$];
  logic         got_last[$];
  logic [511:0] exp_blocks[$];

  sha256_padder #(.LEN_W(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_last     (in_last),
    .in_bytes    (in_bytes),
    .core_busy   (core_busy),
    .blk_data    (blk_data),
    .blk_start   (blk_start),
    .first_block (first_block),
    .last_block  (last_block)
  );

  always #5 clk = ~clk;

  // Block monitor plus a simple hash-controller stand-in (busy for a few cycles per block).
  initial forever begin
    @(negedge clk);
    if (blk_start === 1'b1) begin
      got_data.push_back(blk_data);
      got_first.push_back(first_block);
      got_last.push_back(last_block);
      if (auto_busy) busy_cnt = $urandom_range(1, 5);
    end
    if (auto_busy) begin
      if (busy_cnt > 0) begin
        core_busy = 1'b1;
        busy_cnt--;
      end else begin
        core_busy = 1'b0;
      end
    end
  end

  // Reference padding: message bytes, 0x80, zeros to 56 mod 64, 64-bit big-endian bit count.
  task automatic make_expected(input byte unsigned msg[$]);
    byte unsigned p[$];
    logic [63:0]  bitlen;
    logic [511:0] blk;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bitlen = 64'(msg.size()) << 3;
    for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
    exp_blocks.delete();
    for (int b = 0; b < p.size() / 64; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
      exp_blocks.push_back(blk);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic put_word(input logic [31:0] d, input logic [2:0] nb, input logic lst);
    int t = 0;
    in_data  = d;
    in_bytes = nb;
    in_last  = lst;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL put_word timeout: in_ready=%b, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_msg(input byte unsigned msg[$], input bit tail, input int gap);
    int          n = msg.size();
    int          i = 0;
    int          nb;
    bit          et;
    logic [31:0] w;
    et = tail && (n % 4 == 0);
    if (n == 0) begin
      put_word($urandom, 3'd0, 1'b1);
      return;
    end
    while (i < n) begin
      nb = (n - i >= 4) ? 4 : n - i;
      w  = $urandom;
      for (int k = 0; k < nb; k++) w[31-8*k -: 8] = msg[i+k];
      i += nb;
      put_word(w, 3'(nb), (i == n) && !et);
      repeat ($urandom_range(0, gap)) @(negedge clk);
    end
    if (et) put_word($urandom, 3'd0, 1'b1);
  endtask

  task automatic drive_msg(input byte unsigned msg[$], input bit tail, input int gap,
                           input int nblk);
    int t = 0;
    got_data.delete();
    got_first.delete();
    got_last.delete();
    send_msg(msg, tail, gap);
    while (got_data.size() < nblk && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, blk_start, first_block, last_block} !== 4'b0 || blk_data !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: ready/start/first/last=%b data=%h, required all 0",
               {in_ready, blk_start, first_block, last_block}, blk_data);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset idle ready: in_ready=%b, required 0", in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset fill ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_abc();
    byte unsigned msg[$] = '{8'h61, 8'h62, 8'h63};
    drive_msg(msg, 1'b0, 0, 1);
    n_checks++;
    if (got_data.size() != 1) begin
      n_fail++;
      $display("FAIL abc count: got %0d blocks, required 1", got_data.size());
    end else begin
      n_checks++;
      if (got_data[0] !== {32'h61626380, 448'h0, 32'h00000018}) begin
        n_fail++;
        $display("FAIL abc data: got %h, required 61626380..00000018", got_data[0]);
      end
      n_checks++;
      if ({got_first[0], got_last[0]} !== 2'b11) begin
        n_fail++;
        $display("FAIL abc flags: first/last=%b, required 11", {got_first[0], got_last[0]});
      end
    end
  endtask

  task automatic test_empty();
    byte unsigned msg[$];
    drive_msg(msg, 1'b0, 0, 1);
    n_checks++;
    if (got_data.size() != 1 || got_data[0] !== {32'h80000000, 480'h0} ||
        {got_first[0], got_last[0]} !== 2'b11) begin
      n_fail++;
      $display("FAIL empty block: count=%0d data=%h, required 1 block 80000000 then zeros",
               got_data.size(), got_data.size() > 0 ? got_data[0] : '0);
    end
  endtask

  task automatic test_56();
    byte unsigned msg[$];
    for (int i = 0; i < 56; i++) msg.push_back(8'($urandom));
    make_expected(msg);
    drive_msg(msg, 1'b0, 1, 2);
    n_checks++;
    if (got_data.size() != 2) begin
      n_fail++;
      $display("FAIL len56 count: got %0d blocks, required 2", got_data.size());
    end else begin
      n_checks++;
      if (got_data[0][63:0] !== 64'h80000000_00000000 || got_data[0] !== exp_blocks[0] ||
          {got_first[0], got_last[0]} !== 2'b10) begin
        n_fail++;
        $display("FAIL len56 block1: got %h f/l=%b, required %h f/l=10", got_data[0],
                 {got_first[0], got_last[0]}, exp_blocks[0]);
      end
      n_checks++;
      if (got_data[1] !== {480'h0, 32'h000001C0} || {got_first[1], got_last[1]} !== 2'b01) begin
        n_fail++;
        $display("FAIL len56 block2: got %h f/l=%b, required zeros..000001c0 f/l=01",
                 got_data[1], {got_first[1], got_last[1]});
      end
    end
  endtask

  task automatic test_64();
    byte unsigned msg[$];
    for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
    make_expected(msg);
    drive_msg(msg, 1'b0, 0, 2);
    n_checks++;
    if (got_data.size() != 2) begin
      n_fail++;
      $display("FAIL len64 count: got %0d blocks, required 2", got_data.size());
    end else begin
      n_checks++;
      if (got_data[0] !== exp_blocks[0] || {got_first[0], got_last[0]} !== 2'b10) begin
        n_fail++;
        $display("FAIL len64 block1: got %h f/l=%b, required %h f/l=10", got_data[0],
                 {got_first[0], got_last[0]}, exp_blocks[0]);
      end
      n_checks++;
      if (got_data[1] !== {32'h80000000, 448'h0, 32'h00000200} ||
          {got_first[1], got_last[1]} !== 2'b01) begin
        n_fail++;
        $display("FAIL len64 block2: got %h f/l=%b, required 80000000..00000200 f/l=01",
                 got_data[1], {got_first[1], got_last[1]});
      end
    end
  endtask

  task automatic test_busy_hold();
    bit quiet = 1'b1;
    auto_busy = 1'b0;
    core_busy = 1'b1;
    got_data.delete();
    got_first.delete();
    got_last.delete();
    put_word({24'h616263, 8'($urandom)}, 3'd3, 1'b1);
    repeat (70) begin
      @(negedge clk);
      if (blk_start !== 1'b0 || in_ready !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL busy hold: blk_start or in_ready rose while busy (start=%b ready=%b)",
               blk_start, in_ready);
    end
    core_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (blk_start !== 1'b1) begin
      n_fail++;
      $display("FAIL busy release pulse: blk_start=%b, required 1", blk_start);
    end
    core_busy = 1'b1;
    @(negedge clk);
    n_checks++;
    if (blk_start !== 1'b0) begin
      n_fail++;
      $display("FAIL busy pulse width: blk_start=%b, required 0", blk_start);
    end
    core_busy = 1'b0;
    auto_busy = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (got_data.size() != 1 || got_data[0] !== {32'h61626380, 448'h0, 32'h00000018}) begin
      n_fail++;
      $display("FAIL busy block: count=%0d, required exactly one abc block", got_data.size());
    end
  endtask

  task automatic test_reset_mid_fill();
    byte unsigned msg[$] = '{8'h61, 8'h62, 8'h63};
    for (int i = 0; i < 5; i++) put_word($urandom, 3'd4, 1'b0);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, blk_start, first_block, last_block} !== 4'b0 || blk_data !== '0) begin
      n_fail++;
      $display("FAIL midfill reset outputs: ready/start/first/last=%b data=%h, required all 0",
               {in_ready, blk_start, first_block, last_block}, blk_data);
    end
    busy_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    drive_msg(msg, 1'b0, 0, 1);
    n_checks++;
    if (got_data.size() != 1 || got_data[0] !== {32'h61626380, 448'h0, 32'h00000018} ||
        {got_first[0], got_last[0]} !== 2'b11) begin
      n_fail++;
      $display("FAIL midfill abc: count=%0d data=%h, required one abc block with f/l=11",
               got_data.size(), got_data.size() > 0 ? got_data[0] : '0);
    end
  endtask

  task automatic test_random();
    int lens[$] = '{0, 1, 3, 4, 52, 55, 56, 57, 60, 63, 64, 65, 119, 120, 128};
    for (int r = 0; r < 6; r++) lens.push_back($urandom_range(0, 140));
    foreach (lens[m]) begin
      byte unsigned msg[$];
      bit tail;
      for (int i = 0; i < lens[m]; i++) msg.push_back(8'($urandom));
      tail = 1'($urandom_range(0, 1));
      make_expected(msg);
      drive_msg(msg, tail, 2, exp_blocks.size());
      n_checks++;
      if (got_data.size() != exp_blocks.size()) begin
        n_fail++;
        $display("FAIL rand len %0d count: got %0d blocks, required %0d", lens[m],
                 got_data.size(), exp_blocks.size());
      end
      for (int b = 0; b < exp_blocks.size() && b < got_data.size(); b++) begin
        n_checks++;
        if (got_data[b] !== exp_blocks[b] || got_first[b] !== (b == 0) ||
            got_last[b] !== (b == exp_blocks.size() - 1)) begin
          n_fail++;
          $display("FAIL rand len %0d blk %0d: got %h f/l=%b, required %h f/l=%b", lens[m], b,
                   got_data[b], {got_first[b], got_last[b]}, exp_blocks[b],
                   {b == 0, b == exp_blocks.size() - 1});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_56();
    test_64();
    test_busy_hold();
    test_reset_mid_fill();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
